jk_excite_gen: RTL and testbench

JK_EXCITE_GEN -- requirements
Module: jk_excite_gen

---
 rtl/jk_excite_gen.sv | 186 ++++++++++++++++++
 tb/tb_jk_excite_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_gen.sv
// JK flip-flop excitation generator: queues target Q bits, drives J/K to reach each
// target on an external same-clock JK flip-flop, then checks the result and counts mismatches.
module jk_excite_gen #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             q_in,
  output logic             j,
  output logic             k,
  input  logic             err_clr,
  output logic             chk_valid,
  output logic             chk_ok,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1'b1);
  localparam logic [CNT_W-1:0] ERR_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Excitation map {j,k}; don't-cares resolved to 0 so toggle is never requested.
  function automatic logic [1:0] jk_excite(input logic q, input logic t);
    logic [1:0] jk;
    case ({q, t})
      2'b01:   jk = 2'b10;
      2'b10:   jk = 2'b01;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

  state_t           state_q, state_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             cur_tgt_q, cur_tgt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             chk_valid_q, chk_valid_d;
  logic             chk_ok_q, chk_ok_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic             push_s;
  logic             pop_s;
  logic             head_s;
  logic             mismatch_s;
  logic [1:0]       jk_load_s;

  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == FULL_CNT);
  assign tgt_ready    = rst & ~fifo_full_s;
  assign busy         = rst & ((state_q != ST_IDLE) | ~fifo_empty_s);
  assign push_s       = tgt_valid & tgt_ready;
  // A pop happens wherever a new bit can be launched: from IDLE, or straight out of CHECK.
  assign pop_s        = ~fifo_empty_s & ((state_q == ST_IDLE) | (state_q == ST_CHECK));
  assign head_s       = mem_q[rd_ptr_q];
  assign jk_load_s    = jk_excite(q_in, head_s);
  assign mismatch_s   = (state_q == ST_CHECK) & (q_in != cur_tgt_q);

  assign j         = j_q;
  assign k         = k_q;
  assign chk_valid = chk_valid_q;
  assign chk_ok    = chk_ok_q;
  assign err_cnt   = err_cnt_q;

  // Sequencer next state: launch, drive for one cycle, then check and relaunch.
  always_comb begin
    state_d     = state_q;
    j_d         = 1'b0;
    k_d         = 1'b0;
    cur_tgt_d   = cur_tgt_q;
    chk_valid_d = 1'b0;
    chk_ok_d    = chk_ok_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d    = ST_DRIVE;
          {j_d, k_d} = jk_load_s;
          cur_tgt_d  = head_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        chk_valid_d = 1'b1;
        chk_ok_d    = (q_in == cur_tgt_q);
        if (pop_s) begin
          state_d    = ST_DRIVE;
          {j_d, k_d} = jk_load_s;
          cur_tgt_d  = head_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Target FIFO pointers, storage and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = tgt_bit;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Saturating mismatch counter; a clear request overrides a simultaneous mismatch.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (mismatch_s && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cur_tgt_q   <= 1'b0;
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_ok_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cur_tgt_q   <= cur_tgt_d;
      j_q         <= j_d;
      k_q         <= k_d;
      chk_valid_q <= chk_valid_d;
      chk_ok_q    <= chk_ok_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_jk_excite_gen.sv
// Directed bench for jk_excite_gen: an external JK flip-flop model closes the loop,
// with a second instance (CNT_W=2) for counter saturation.
module tb_jk_excite_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, tgt_valid = 1'b0, tgt_bit = 1'b0, err_clr = 1'b0;
  logic       tgt_ready, q_in, j, k, chk_valid, chk_ok, busy;
  logic [7:0] err_cnt;

  logic       rst2 = 1'b0, tgt_valid2 = 1'b0, tgt_bit2 = 1'b0;
  logic       tgt_ready2, j2, k2, chk_valid2, chk_ok2, busy2;
  logic [1:0] err_cnt2;

  logic       q_ff  = 1'b0;
  logic       fault = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;

  assign q_in = fault ? 1'b0 : q_ff;

  // External JK flip-flop on the same clock.
  always @(posedge clk) begin
    case ({j, k})
      2'b10:   q_ff <= 1'b1;
      2'b01:   q_ff <= 1'b0;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end

  jk_excite_gen #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(tgt_ready),
    .q_in(q_in), .j(j), .k(k), .err_clr(err_clr), .chk_valid(chk_valid), .chk_ok(chk_ok),
    .err_cnt(err_cnt), .busy(busy)
  );

  jk_excite_gen #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .tgt_valid(tgt_valid2), .tgt_bit(tgt_bit2), .tgt_ready(tgt_ready2),
    .q_in(1'b0), .j(j2), .k(k2), .err_clr(1'b0), .chk_valid(chk_valid2), .chk_ok(chk_ok2),
    .err_cnt(err_cnt2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rst2 = 1'b0;
    tick(); tick();
    n_checks++; if ({j, k} !== 2'b00) begin n_fail++; $display("FAIL reset_jk: got %b expected 00", {j, k}); end
    n_checks++; if (chk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_chk_valid: got %b expected 0", chk_valid); end
    n_checks++; if (chk_ok !== 1'b0) begin n_fail++; $display("FAIL reset_chk_ok: got %b expected 0", chk_ok); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    n_checks++; if (tgt_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b expected 0", tgt_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b1; rst2 = 1'b1;
    tick();
    n_checks++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", tgt_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    tgt_valid = 1'b1; tgt_bit = 1'b1;
    tick();  // E0
    tgt_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    tick();  // E1 -> DRIVE
    n_checks++; if ({j, k} !== 2'b10) begin n_fail++; $display("FAIL single_drive_jk: got %b expected 10", {j, k}); end
    n_checks++; if (chk_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", chk_valid); end
    tick();  // E2 -> CHECK
    n_checks++; if ({j, k} !== 2'b00) begin n_fail++; $display("FAIL single_check_jk: got %b expected 00", {j, k}); end
    tick();  // E3 -> result
    n_checks++; if (chk_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", chk_valid); end
    n_checks++; if (chk_ok !== 1'b1) begin n_fail++; $display("FAIL single_ok: got %b expected 1", chk_ok); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL single_err: got %0d expected 0", err_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    tick();
    n_checks++; if (chk_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse_len: got %b expected 0", chk_valid); end
  endtask

  task automatic test_burst();
    logic [3:0] bits;
    logic [1:0] exp_jk [9];
    logic       exp_cv [9];
    // Bring the external flip-flop to 0 first.
    tgt_valid = 1'b1; tgt_bit = 1'b0;
    tick();
    tgt_valid = 1'b0;
    tick(); tick(); tick(); tick();
    bits   = 4'b1001;  // pushed LSB first: 1,0,0,1
    exp_jk = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    exp_cv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tgt_valid = 1'b1; tgt_bit = bits[0];
    tick();  // E0
    for (int i = 0; i < 9; i++) begin
      tgt_valid = (i < 3);
      tgt_bit   = (i < 3) ? bits[i+1] : 1'b0;
      tick();
      n_checks++; if ({j, k} !== exp_jk[i]) begin n_fail++; $display("FAIL burst_jk[%0d]: got %b expected %b", i+1, {j, k}, exp_jk[i]); end
      n_checks++; if (chk_valid !== exp_cv[i]) begin n_fail++; $display("FAIL burst_valid[%0d]: got %b expected %b", i+1, chk_valid, exp_cv[i]); end
      if (exp_cv[i]) begin
        n_checks++; if (chk_ok !== 1'b1) begin n_fail++; $display("FAIL burst_ok[%0d]: got %b expected 1", i+1, chk_ok); end
      end
      if (i == 7) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL burst_busy_check: got %b expected 1", busy); end
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_full();
    logic [7:0] fbits;
    logic       rdy;
    int         idx;
    int         npulse;
    int         extra;
    fbits  = 8'b0100_1101;  // b0..b7 = 1,0,1,1,0,0,1,0
    idx    = 0;
    npulse = 0;
    extra  = 0;
    for (int c = 0; c < 60 && npulse < 8; c++) begin
      tgt_valid = (idx < 8);
      tgt_bit   = (idx < 8) ? fbits[idx] : 1'b0;
      rdy       = tgt_ready;
      tick();
      if (rdy && tgt_valid) idx++;
      if (c == 5) begin
        n_checks++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_c5: got %b expected 1", tgt_ready); end
      end
      if (c == 6) begin
        n_checks++; if (tgt_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %b expected 0", tgt_ready); end
        n_checks++; if (idx !== 7) begin n_fail++; $display("FAIL full_accepted: got %0d expected 7", idx); end
      end
      if (c == 7) begin
        n_checks++; if (tgt_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_pop: got %b expected 1", tgt_ready); end
      end
      if (c == 8) begin
        n_checks++; if (idx !== 8) begin n_fail++; $display("FAIL full_held_bit: got %0d expected 8", idx); end
      end
      if (chk_valid) begin
        n_checks++; if (chk_ok !== 1'b1) begin n_fail++; $display("FAIL full_ok[%0d]: got %b expected 1", npulse, chk_ok); end
        n_checks++; if (q_ff !== fbits[npulse]) begin n_fail++; $display("FAIL full_order[%0d]: got %b expected %b", npulse, q_ff, fbits[npulse]); end
        npulse++;
      end
    end
    tgt_valid = 1'b0;
    n_checks++; if (npulse !== 8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", npulse); end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (chk_valid) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL full_duplicate: got %0d expected 0", extra); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_fault();
    int npulse;
    int nbad;
    npulse = 0;
    nbad   = 0;
    fault  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tgt_valid = (c < 3); tgt_bit = 1'b1;
      tick();
      if (chk_valid) begin
        npulse++;
        if (!chk_ok) nbad++;
        n_checks++; if (err_cnt !== 8'(npulse)) begin n_fail++; $display("FAIL fault_err[%0d]: got %0d expected %0d", npulse, err_cnt, npulse); end
      end
    end
    tgt_valid = 1'b0;
    n_checks++; if (nbad !== 3) begin n_fail++; $display("FAIL fault_bad_count: got %0d expected 3", nbad); end
    n_checks++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL fault_err_total: got %0d expected 3", err_cnt); end
    tgt_valid = 1'b1; tgt_bit = 1'b1;
    tick();  // E0
    tgt_valid = 1'b0;
    tick(); tick();  // E1 DRIVE, E2 CHECK
    n_checks++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL fault_err_hold: got %0d expected 3", err_cnt); end
    err_clr = 1'b1;
    tick();  // E3: mismatch and clear together
    err_clr = 1'b0;
    n_checks++; if (chk_valid !== 1'b1 || chk_ok !== 1'b0) begin n_fail++; $display("FAIL fault_4th: got valid=%b ok=%b expected valid=1 ok=0", chk_valid, chk_ok); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL fault_clear_wins: got %0d expected 0", err_cnt); end
    fault = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    int  npulse;
    int  idx;
    int  exp_e;
    logic rdy;
    npulse = 0;
    idx    = 0;
    for (int c = 0; c < 40 && npulse < 5; c++) begin
      tgt_valid2 = (idx < 5); tgt_bit2 = 1'b1;
      rdy        = tgt_ready2;
      tick();
      if (rdy && tgt_valid2) idx++;
      if (chk_valid2) begin
        npulse++;
        exp_e = (npulse > 3) ? 3 : npulse;
        n_checks++; if (err_cnt2 !== 2'(exp_e)) begin n_fail++; $display("FAIL sat_err[%0d]: got %0d expected %0d", npulse, err_cnt2, exp_e); end
        n_checks++; if (chk_ok2 !== 1'b0) begin n_fail++; $display("FAIL sat_ok[%0d]: got %b expected 0", npulse, chk_ok2); end
      end
    end
    tgt_valid2 = 1'b0;
    n_checks++; if (npulse !== 5) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 5", npulse); end
    tick(); tick(); tick();
    n_checks++; if (err_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d expected 3", err_cnt2); end
    n_checks++; if ({j2, k2, busy2} !== 3'b000) begin n_fail++; $display("FAIL sat_idle: got %b expected 000", {j2, k2, busy2}); end
  endtask

  task automatic test_reset_mid();
    int nv;
    int njk;
    nv    = 0;
    njk   = 0;
    fault = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tgt_valid = 1'b1; tgt_bit = 1'b1;
      tick();  // E0..E3
    end
    tgt_valid = 1'b0;
    n_checks++; if ({j, k} !== 2'b10) begin n_fail++; $display("FAIL rstmid_drive: got %b expected 10", {j, k}); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL rstmid_err_pre: got %0d expected 1", err_cnt); end
    rst = 1'b0;
    tick();
    n_checks++; if ({j, k} !== 2'b00) begin n_fail++; $display("FAIL rstmid_jk: got %b expected 00", {j, k}); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_err: got %0d expected 0", err_cnt); end
    n_checks++; if (chk_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", chk_valid); end
    n_checks++; if ({tgt_ready, busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_ready_busy: got %b expected 00", {tgt_ready, busy}); end
    rst   = 1'b1;
    fault = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (chk_valid) nv++;
      if (j || k) njk++;
    end
    n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL rstmid_no_check: got %0d expected 0", nv); end
    n_checks++; if (njk !== 0) begin n_fail++; $display("FAIL rstmid_no_drive: got %0d expected 0", njk); end
    n_checks++; if ({tgt_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL rstmid_empty: got %b expected 10", {tgt_ready, busy}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_fault();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
